// File: rtl/text_gpu.sv
// text_gpu: parametrised text-mode VGA generator with double-buffered RGB332 cell memory,
// a valid/ready command port and frame-synchronous buffer swap.
module text_gpu #(
    parameter int COLS         = 80,
    parameter int ROWS         = 60,
    parameter int CELL_W       = 8,
    parameter int CELL_H       = 8,
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 752,
    parameter int H_TOTAL      = 800,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 492,
    parameter int V_TOTAL      = 525
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic [7:0] red_out,
    output logic [7:0] green_out,
    output logic [7:0] blue_out,
    output logic       hsync,
    output logic       vsync,
    output logic       de
);
    localparam int N  = COLS * ROWS;
    localparam int AW = $clog2(N);
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HA     = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS0    = HW'(H_SYNC_START);
    localparam logic [HW-1:0] HS1    = HW'(H_SYNC_END);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VA     = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS0    = VW'(V_SYNC_START);
    localparam logic [VW-1:0] VS1    = VW'(V_SYNC_END);
    localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);
    localparam logic [AW-1:0] A_LAST = AW'(N - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;

    state_t          state, state_n;
    logic [HW-1:0]   h;
    logic [VW-1:0]   v;
    logic [XW-1:0]   cx, cx_n, mx;
    logic [YW-1:0]   cy, cy_n, my;
    logic            front, front_n;
    logic [AW-1:0]   cnt, cnt_n, wa, ra;
    logic [7:0]      fill, fill_n, wd, pix;
    logic            we, accept, vis, vis1, hs1, vs1;
    logic [7:0]      mem0 [N];
    logic [7:0]      mem1 [N];

    assign cmd_ready = state == IDLE && !rst;
    assign busy      = state != IDLE;
    assign accept    = cmd_valid && cmd_ready;
    assign vis       = h < HA && v < VA;
    assign ra        = vis ? AW'(32'(v >> $clog2(CELL_H)) * COLS + 32'(h >> $clog2(CELL_W))) : '0;
    assign mx        = 32'(cmd_data[6:0]) >= COLS ? X_LAST : XW'(cmd_data[6:0]);
    assign my        = 32'(cmd_data[6:0]) >= ROWS ? Y_LAST : YW'(cmd_data[6:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else begin
            h <= h == H_LAST ? '0 : h + 1'b1;
            if (h == H_LAST) v <= v == V_LAST ? '0 : v + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cx    <= '0;
            cy    <= '0;
            front <= 1'b0;
            cnt   <= '0;
            fill  <= '0;
        end else begin
            state <= state_n;
            cx    <= cx_n;
            cy    <= cy_n;
            front <= front_n;
            cnt   <= cnt_n;
            fill  <= fill_n;
        end
    end

    always_comb begin
        state_n = state;
        cx_n    = cx;
        cy_n    = cy;
        front_n = front;
        cnt_n   = cnt;
        fill_n  = fill;
        we      = 1'b0;
        wa      = AW'(32'(cy) * COLS + 32'(cx));
        wd      = cmd_data;
        unique case (state)
            IDLE: if (accept) begin
                unique case (cmd_op)
                    2'b00: begin
                        we   = 1'b1;
                        cx_n = cx == X_LAST ? '0 : cx + 1'b1;
                        cy_n = cx != X_LAST ? cy : cy == Y_LAST ? '0 : cy + 1'b1;
                    end
                    2'b01: begin
                        cx_n = cmd_data[7] ? mx : cx;
                        cy_n = cmd_data[7] ? cy : my;
                    end
                    2'b10: state_n = SWAP_WAIT;
                    2'b11: begin
                        state_n = CLEAR;
                        fill_n  = cmd_data;
                        cnt_n   = '0;
                    end
                endcase
            end
            CLEAR: begin
                we    = !rst;
                wa    = cnt;
                wd    = fill;
                cnt_n = cnt + 1'b1;
                if (cnt == A_LAST) begin
                    state_n = IDLE;
                    cx_n    = '0;
                    cy_n    = '0;
                end
            end
            SWAP_WAIT: if (h == '0 && v == VA) begin
                front_n = !front;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Writes always land in the back buffer; the display reads the front one.
    always_ff @(posedge clk) begin
        if (we && front) mem0[wa] <= wd;
        if (we && !front) mem1[wa] <= wd;
        pix <= front ? mem1[ra] : mem0[ra];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vis1      <= 1'b0;
            hs1       <= 1'b1;
            vs1       <= 1'b1;
            de        <= 1'b0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            red_out   <= '0;
            green_out <= '0;
            blue_out  <= '0;
        end else begin
            vis1      <= vis;
            hs1       <= !(h >= HS0 && h < HS1);
            vs1       <= !(v >= VS0 && v < VS1);
            de        <= vis1;
            hsync     <= hs1;
            vsync     <= vs1;
            red_out   <= vis1 ? {pix[7:5], pix[7:5], pix[7:6]} : '0;
            green_out <= vis1 ? {pix[4:2], pix[4:2], pix[4:3]} : '0;
            blue_out  <= vis1 ? {4{pix[1:0]}} : '0;
        end
    end
endmodule

// File: tb/tb_text_gpu.sv
// tb_text_gpu: self-checking bench for text_gpu on a reduced geometry,
// with a cycle-level reference model of the raster, buffers and commands.
module tb_text_gpu;
    localparam int COLS = 4, ROWS = 3, CW = 2, CH = 2;
    localparam int HA = 8, HSS = 9, HSE = 11, HT = 12;
    localparam int VA = 6, VSS = 7, VSE = 8, VT = 9;
    localparam int N = COLS * ROWS, FR = HT * VT, LIM = 4 * FR;

    logic       clk = 0, rst = 1, cmd_valid = 0;
    logic [1:0] cmd_op = 0;
    logic [7:0] cmd_data = 0;
    logic       cmd_ready, busy, hsync, vsync, de;
    logic [7:0] red_out, green_out, blue_out;
    int         checks = 0, failures = 0;

    text_gpu #(
        .COLS(COLS), .ROWS(ROWS), .CELL_W(CW), .CELL_H(CH),
        .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .busy(busy),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .hsync(hsync), .vsync(vsync), .de(de)
    );

    always #5 clk = ~clk;

    typedef struct { logic [23:0] rgb; bit de, hs, vs, known; int h, v; } pix_t;
    typedef struct { logic [7:0] mx, my, val; int ex, ey; } vec_t;

    logic [7:0]  mem [2][N];
    bit          kn [2][N];
    int          mh = 0, mv = 0, cx = 0, cy = 0, front = 0, clr_left = 0, clr_idx = 0, tcnt = 0, ready_t = 0;
    bit          swap_pend = 0, armed = 0;
    logic [7:0]  clr_val = 0;
    pix_t        e1, e2;
    logic [23:0] cap [VA][HA];

    // 3-bit channels scale to 0..255 with rounding, 2-bit blue by 85.
    function automatic logic [23:0] expand(logic [7:0] c);
        int r = int'(c[7:5]), g = int'(c[4:2]), b = int'(c[1:0]);
        return {8'((r * 255 + 3) / 7), 8'((g * 255 + 3) / 7), 8'(b * 85)};
    endfunction

    function automatic pix_t idle_pix();
        pix_t p;
        p.rgb = '0; p.de = 0; p.hs = 1; p.vs = 1; p.known = 1; p.h = 0; p.v = 0;
        return p;
    endfunction

    function automatic int clampv(logic [7:0] d, int lim);
        return int'(d[6:0]) > lim - 1 ? lim - 1 : int'(d[6:0]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        pix_t p;
        int a;
        p = idle_pix();
        p.h = mh; p.v = mv;
        p.de = mh < HA && mv < VA;
        p.hs = !(mh >= HSS && mh < HSE);
        p.vs = !(mv >= VSS && mv < VSE);
        if (p.de) begin
            a = (mv / CH) * COLS + mh / CW;
            p.known = kn[front][a];
            p.rgb = expand(mem[front][a]);
        end
        if (rst) begin
            e1 = idle_pix(); e2 = idle_pix();
            mh = 0; mv = 0; cx = 0; cy = 0; front = 0; clr_left = 0; swap_pend = 0; tcnt = 0;
            armed = 1;
        end else begin
            e2 = e1; e1 = p;
            if (clr_left > 0) begin
                mem[1-front][clr_idx] = clr_val; kn[1-front][clr_idx] = 1;
                clr_idx++; clr_left--;
                if (clr_left == 0) begin cx = 0; cy = 0; end
            end else if (swap_pend) begin
                if (mh == 0 && mv == VA) begin front = 1 - front; swap_pend = 0; end
            end else if (cmd_valid) begin
                case (cmd_op)
                    2'd0: begin
                        a = cy * COLS + cx;
                        mem[1-front][a] = cmd_data; kn[1-front][a] = 1;
                        cx++;
                        if (cx == COLS) begin cx = 0; cy = (cy + 1) % ROWS; end
                    end
                    2'd1: if (cmd_data[7]) cx = clampv(cmd_data, COLS); else cy = clampv(cmd_data, ROWS);
                    2'd2: swap_pend = 1;
                    default: begin clr_left = N; clr_idx = 0; clr_val = cmd_data; end
                endcase
            end
            tcnt++;
            mh = (mh + 1) % HT;
            if (mh == 0) mv = (mv + 1) % VT;
        end
    end

    always @(posedge clk) begin
        #2;
        if (armed) begin
            chk("cmd_ready", cmd_ready, !rst && clr_left == 0 && !swap_pend);
            chk("busy", busy, clr_left > 0 || swap_pend);
            chk("de", de, e2.de);
            chk("hsync", hsync, e2.hs);
            chk("vsync", vsync, e2.vs);
            if (e2.known) chk("rgb", {red_out, green_out, blue_out}, e2.rgb);
            if (e2.de) cap[e2.v][e2.h] = {red_out, green_out, blue_out};
        end
    end

    task automatic send(input logic [1:0] op, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_op = op; cmd_data = d;
        while (!cmd_ready && n < LIM) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            checks++; failures++;
            $display("FAIL send_timeout: cmd_ready got 0 expected 1 after %0d cycles", LIM);
        end
        ready_t = tcnt;
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < LIM) begin @(negedge clk); n++; end
        if (busy) begin
            checks++; failures++;
            $display("FAIL wait_idle: busy got 1 expected 0 after %0d cycles", LIM);
        end
    endtask

    task automatic swap_and_frame();
        send(2'd2, 8'h00);
        wait_idle();
        repeat (FR) @(negedge clk);
    endtask

    task automatic chk_cell(input string name, input int x, input int y, input logic [7:0] c);
        chk(name, cap[y*CH][x*CW], expand(c));
        chk(name, cap[y*CH+CH-1][x*CW+CW-1], expand(c));
    endtask

    initial begin
        vec_t tbl [5];
        int hs_low = 0, vs_low = 0, de_n = 0, hs_first = -1, vs_f0 = -1, vs_f1 = -1, n = 0, red_n = 0;
        logic prev_vs = 1;
        logic [1:0] op;
        tbl[0] = '{8'hFF, 8'h7F, 8'h55, 3, 2};
        tbl[1] = '{8'h80, 8'h00, 8'h11, 0, 0};
        tbl[2] = '{8'h81, 8'h01, 8'h22, 1, 1};
        tbl[3] = '{8'h82, 8'h7F, 8'h33, 2, 2};
        tbl[4] = '{8'hC0, 8'h01, 8'h44, 3, 1};

        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_outputs", {hsync, vsync, de, red_out, green_out, blue_out}, {3'b110, 24'h0});
        rst = 0;
        #1 chk("ready_release", cmd_ready, 1);

        for (int i = 0; i < 2 * FR; i++) begin
            @(negedge clk);
            hs_low += int'(!hsync); vs_low += int'(!vsync); de_n += int'(de);
            if (!hsync && hs_first < 0) hs_first = tcnt;
            if (prev_vs && !vsync) begin
                if (vs_f0 < 0) vs_f0 = tcnt; else if (vs_f1 < 0) vs_f1 = tcnt;
            end
            prev_vs = vsync;
        end
        chk("hsync_low_clocks", hs_low, 2 * VT * (HSE - HSS));
        chk("vsync_low_clocks", vs_low, 2 * HT * (VSE - VSS));
        chk("de_clocks", de_n, 2 * HA * VA);
        chk("hsync_first", hs_first, HSS + 2);
        chk("vsync_first", vs_f0, VSS * HT + 2);
        chk("frame_len", vs_f1 - vs_f0, FR);

        send(2'd3, 8'hE0);
        while (busy && n < LIM) begin n++; @(negedge clk); end
        chk("clear_busy_cycles", n, N);
        swap_and_frame();
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++) red_n += int'(cap[y][x] == 24'hFF0000);
        chk("clear_frame_red", red_n, HA * VA);

        send(2'd1, 8'h83);
        send(2'd1, 8'h02);
        send(2'd0, 8'h03);
        send(2'd0, 8'h1C);
        send(2'd0, 8'hE3);
        swap_and_frame();
        chk_cell("wrap_last_cell", 3, 2, 8'h03);
        chk_cell("wrap_first_cell", 0, 0, 8'h1C);
        chk_cell("wrap_cursor", 1, 0, 8'hE3);

        foreach (tbl[i]) begin
            send(2'd1, tbl[i].mx);
            send(2'd1, tbl[i].my);
            send(2'd0, tbl[i].val);
        end
        swap_and_frame();
        foreach (tbl[i]) chk_cell("move_clamp", tbl[i].ex, tbl[i].ey, tbl[i].val);

        n = 0;
        while (mv != 2 && n < LIM) begin @(negedge clk); n++; end
        send(2'd2, 8'h00);
        send(2'd0, 8'h1C);
        chk("swap_h", ready_t % HT, 1);
        chk("swap_v", (ready_t / HT) % VT, VA);
        wait_idle();

        send(2'd3, 8'h55);
        repeat (5) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", cmd_ready, 1);
        send(2'd0, 8'h1C);
        swap_and_frame();
        chk_cell("abort_cursor", 0, 0, 8'h1C);

        for (int i = 0; i < 150; i++) begin
            n = int'($urandom_range(0, 99));
            op = n < 50 ? 2'd0 : n < 85 ? 2'd1 : n < 95 ? 2'd2 : 2'd3;
            send(op, 8'($urandom));
        end
        wait_idle();
        swap_and_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/text_gpu.md
# text_gpu

Parametrised text-mode video generator with double-buffered cell memory, a valid/ready command port and built-in VGA raster timing. Successor to the fixed 80x60 block. Adds generic geometry, sync generation, tear-free buffer swap on frame boundaries, and a real CLEAR command. Sits between the CPU bus interface (command side) and the DAC/video connector (pixel side).

## Interface
- COLS, 80, text columns; COLS*ROWS ≤ 2^16.
- ROWS, 60, text rows.
- CELL_W, 8, pixels per cell horizontally (power of 2).
- CELL_H, 8, pixels per cell vertically (power of 2).
- H_ACTIVE / H_SYNC_START / H_SYNC_END / H_TOTAL, 640 / 656 / 752 / 800, horizontal timing in clocks.
- V_ACTIVE / V_SYNC_START / V_SYNC_END / V_TOTAL, 480 / 490 / 492 / 525, vertical timing in lines.
- clk  in  1  pixel clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  00 STORE, 01 MOVE, 10 DISPLAY, 11 CLEAR.
- cmd_data  in  8  operand.
- busy  out  1  CLEAR or swap in progress.
- red_out, green_out, blue_out  out  8 each  pixel colour.
- hsync, vsync  out  1 each  active-low sync.
- de  out  1  pixel in active area.

## Operation
- Memory: two buffers of COLS*ROWS bytes, RGB332 per cell. `front` selects the displayed buffer; the other is the back buffer. Contents are not reset.
- Cursor (cx, cy) addresses the back buffer; cell address = cy*COLS + cx.
- States: IDLE, CLEAR, SWAP_WAIT. cmd_ready = (state==IDLE) && !rst. busy = (state!=IDLE).
- STORE (IDLE): write cmd_data to back[cx,cy]. Advance cx. At cx==COLS-1, set cx=0 and advance cy. At cy==ROWS-1, wrap cy to 0. Stays IDLE.
- MOVE (IDLE): absolute positioning. If cmd_data[7]=1: cx = min(cmd_data[6:0], COLS-1). Else cy = min(cmd_data[6:0], ROWS-1).
- DISPLAY (IDLE→SWAP_WAIT): front toggles on the first cycle the raster counter equals (h=0, v=V_ACTIVE), then return to IDLE. A DISPLAY accepted in that exact cycle waits for the next frame.
- CLEAR (IDLE→CLEAR): latch cmd_data. Write it to back-buffer addresses 0..COLS*ROWS-1, one per cycle (COLS*ROWS cycles). Then cx=cy=0 and return to IDLE. The front buffer keeps displaying throughout.
- Raster: h counts 0..H_TOTAL-1 and wraps. v increments when h wraps, over 0..V_TOTAL-1, and wraps.
- Visible when h<H_ACTIVE && v<V_ACTIVE. Cell = (h/CELL_W, v/CELL_H), read from the front buffer.
- Colour expansion by bit replication:
  - R = {r[2:0], r[2:0], r[2:1]}
  - G = {g[2:0], g[2:0], g[2:1]}
  - B = {b[1:0] ×4}
- Outside the visible area RGB = 0 and de = 0.
- hsync = 0 when H_SYNC_START ≤ h < H_SYNC_END. vsync = 0 when V_SYNC_START ≤ v < V_SYNC_END.

## Timing
- Reset values:
  - h = v = 0, cx = cy = 0, front = 0, state IDLE.
  - RGB = 0, de = 0, hsync = vsync = 1, busy = 0.
  - cmd_ready = 0 during rst, 1 on the first cycle after release.
- Display pipeline latency is 2 clocks. RGB, de, hsync and vsync for raster position (h,v) appear 2 cycles after the counter holds (h,v). All four are registered and mutually aligned.
- Command effects are visible in state/cursor the cycle after acceptance. A STORE is readable by the display path after swap.
- A back-buffer write never targets the front buffer. The swap toggles front in a single cycle, so no frame mixes buffers.
- rst mid-CLEAR or mid-SWAP_WAIT: abort immediately, with all reset values. A partially cleared buffer is permitted.
- Cursor arithmetic width: clog2(COLS) and clog2(ROWS). No out-of-range value is ever held.

## Test plan
- Reset/timing: release rst → cmd_ready=1 next cycle. hsync low for exactly 96 clocks per line, beginning 658 clocks after line start. vsync low for 2 lines (1600 clocks). Frame = 420000 clocks.
- CLEAR 0xE0 then DISPLAY: busy=1 for 4800 cycles, then SWAP_WAIT until (0,480). Next frame every active pixel = (0xFF,0x00,0x00), de=1 for 307200 pixels.
- STORE wrap: MOVE 0xCF (x=79), MOVE 0x3B (y=59), STORE 0x03, STORE 0x1C. After swap: cell(79,59) blue = 0xFF, cell(0,0) green = 0xFF, cursor = (1,0).
- MOVE clamp: cmd_data 0xFF → cx=79; 0x7F → cy=59; 0x00 → cy=0.
- Tear-free swap: DISPLAY at v=100 → front unchanged through v=479, toggles at (0,480). STORE issued meanwhile sees cmd_ready=0 until then.
- rst asserted at CLEAR cycle 100 → next cycle state IDLE, busy=0, cursor (0,0), front unchanged from reset (0). cmd_ready=1 after release.
